// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial unsigned subtractor: one 4-bit ripple-borrow stage reused
// over NIBBLES cycles, LSB nibble first, with valid/ready handshakes on
// both the operand side and the result side.

// 4-bit ripple-borrow subtractor: d = x - y - bin, bout = borrow out.
module subtractor_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic br;

  // Ripple the borrow bit by bit from LSB to MSB.
  always_comb begin
    br = bin;
    d  = '0;
    for (int i = 0; i < 4; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    bout = br;
  end

endmodule

module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 borrow_out,
  output logic                 zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t state;
  state_t state_nxt;

  // armed keeps in_ready low until the first clock edge after reset.
  logic          armed;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          borrow_q;
  logic          nonzero_acc;
  logic [3:0]    a_nib_p0;
  logic [3:0]    b_nib_p0;
  logic [W-1:0]  diff_q;
  logic          borrow_out_q;
  logic          zero_q;
  logic [3:0]    stage_diff;
  logic          stage_borrow;

  assign accept = in_valid && in_ready;
  // Counter value c (1..NIBBLES) means nibble c-1 sits in the _p0 registers.
  assign idx    = cnt - CW'(1);

  subtractor_4bit u_stage (
    .x    (a_nib_p0),
    .y    (b_nib_p0),
    .bin  (borrow_q),
    .d    (stage_diff),
    .bout (stage_borrow)
  );

  // State register plus the post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> HOLD after last nibble,
  // HOLD -> IDLE when the consumer takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = armed;
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, nibble fetch into _p0, and result write-back per RUN edge.
  // The first RUN edge only fetches nibble 0, so the last nibble completes
  // NIBBLES+1 edges after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      nonzero_acc  <= 1'b0;
      a_nib_p0     <= '0;
      b_nib_p0     <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else if (accept) begin
      a_q         <= a;
      b_q         <= b;
      borrow_q    <= bin;
      cnt         <= '0;
      nonzero_acc <= 1'b0;
    end else if (state == RUN) begin
      if (cnt != LAST) begin
        a_nib_p0 <= a_q[3:0];
        b_nib_p0 <= b_q[3:0];
        a_q      <= a_q >> 4;
        b_q      <= b_q >> 4;
      end
      if (cnt != '0) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx == CW'(i)) diff_q[4*i +: 4] <= stage_diff;
        end
        borrow_q    <= stage_borrow;
        nonzero_acc <= nonzero_acc | (|stage_diff);
      end
      if (cnt == LAST) begin
        borrow_out_q <= stage_borrow;
        zero_q       <= ~(nonzero_acc | (|stage_diff));
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor with NIBBLES=4.
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        zero;

  int total;
  int bad;

  nibble_serial_subtractor #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full operation: accept, measure latency, check result, optional
  // backpressure in HOLD, release, and check return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, input logic [15:0] ed, input logic eb,
                        input logic ez, input int hold, input bit churn);
    int edges;
    bit rdy_seen;
    @(negedge clk);
    chk({tag, ".rdy"}, in_ready, 1'b1);
    a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!churn) in_valid = 1'b0;
    edges = 0;
    rdy_seen = 1'b0;
    while (!out_valid && edges < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      if (churn) begin
        a = 16'($urandom);
        b = 16'($urandom);
        bin = 1'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, ".lat"}, edges, 5);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bout"}, borrow_out, eb);
    chk({tag, ".zero"}, zero, ez);
    if (churn) chk({tag, ".rdy_run"}, rdy_seen, 1'b0);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".hold_vld"}, out_valid, 1'b1);
        chk({tag, ".hold_rdy"}, in_ready, 1'b0);
        chk({tag, ".hold_diff"}, diff, ed);
        chk({tag, ".hold_bout"}, borrow_out, eb);
        chk({tag, ".hold_zero"}, zero, ez);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".vld_off"}, out_valid, 1'b0);
    chk({tag, ".rdy_back"}, in_ready, 1'b1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #22;
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.diff", diff, 16'h0);
    chk("rst.bout", borrow_out, 1'b0);
    chk("rst.zero", zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready_pre", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("rel.in_ready_post", in_ready, 1'b1);

    run_op("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0);
    run_op("wrap1",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    run_op("wrapb",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    run_op("ripple", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
    run_op("bp",     16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 3, 1'b0);

    // Result holds in IDLE.
    repeat (2) @(negedge clk);
    chk("idle.diff", diff, 16'h9998);
    chk("idle.rdy", in_ready, 1'b1);

    run_op("churn",  16'h5555, 16'h1111, 1'b0, 16'h4444, 1'b0, 1'b0, 0, 1'b1);
    run_op("equal",  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0);

    // Reset during RUN nibble 2 aborts the operation.
    @(negedge clk);
    a = 16'h4321; b = 16'h0123; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready", in_ready, 1'b0);
    chk("abort.out_valid", out_valid, 1'b0);
    chk("abort.diff", diff, 16'h0);
    chk("abort.bout", borrow_out, 1'b0);
    chk("abort.zero", zero, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) chk("abort.no_valid", out_valid, 1'b0);
    end
    chk("abort.idle_diff", diff, 16'h0);

    run_op("after",  16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 Port: clk, input, 1, single clock; all state on rising edge.
REQ-003 Port: rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 Port: in_valid, input, 1, operand set offered.
REQ-005 Port: in_ready, output, 1, block can accept operands.
REQ-006 Port: a, input, W, minuend, unsigned.
REQ-007 Port: b, input, W, subtrahend, unsigned.
REQ-008 Port: bin, input, 1, borrow-in to least-significant nibble.
REQ-009 Port: out_valid, output, 1, result available.
REQ-010 Port: out_ready, input, 1, consumer accepts result.
REQ-011 Port: diff, output, W, result (a - b - bin) mod 2^W.
REQ-012 Port: borrow_out, output, 1, borrow from most-significant nibble.
REQ-013 Port: zero, output, 1, diff == 0.

Function
REQ-014 SHALL use exactly one 4-bit ripple-borrow stage (subtractor_4bit), time-multiplexed over NIBBLES cycles, LSB nibble first.
REQ-015 SHALL implement FSM states IDLE, RUN, HOLD; reset state IDLE.
REQ-016 SHALL assert in_ready only in IDLE; SHALL deassert it in RUN and HOLD.
REQ-017 Input handshake: on an edge with in_valid && in_ready, SHALL latch a, b, and bin into internal registers, clear the nibble counter, and go to RUN.
REQ-018 In RUN, cycle k (k = 0..NIBBLES-1) SHALL subtract nibble k of the latched b from nibble k of the latched a. Borrow-in is latched bin for k=0, otherwise the registered borrow from nibble k-1.
REQ-019 Each RUN edge SHALL write the nibble-k difference into diff[4k+3:4k] and register the stage borrow.
REQ-020 After the edge completing nibble NIBBLES-1, SHALL enter HOLD. This edge also writes borrow_out and zero.
REQ-021 Latency: out_valid SHALL rise exactly NIBBLES+1 edges after the accepting edge (5 for NIBBLES=4).
REQ-022 HOLD: out_valid=1. diff, borrow_out and zero SHALL remain stable until an edge with out_ready=1.
REQ-023 On that edge, SHALL return to IDLE. The same edge SHALL NOT accept new operands; the next accept is earliest one cycle later.
REQ-024 in_valid, a, b and bin changes outside the accepting edge SHALL have no effect on the operation in flight.
REQ-025 out_ready SHALL be ignored outside HOLD.
REQ-026 Arithmetic: borrow_out=1 iff a < b + bin (unsigned, full width). Wrap-around results are modulo 2^W.
REQ-027 diff, borrow_out and zero SHALL hold their last values in IDLE until the next RUN begins overwriting them.
REQ-028 Partial diff values during RUN are not valid and SHALL NOT be qualified by out_valid.

Reset
REQ-029 While rst_n=0, outputs SHALL be: in_ready=0, out_valid=0, diff=0, borrow_out=0, zero=0. The FSM SHALL be in IDLE, with counter and internal registers cleared.
REQ-030 On the first edge with rst_n=1, SHALL raise in_ready in IDLE. Assertion mid-RUN or mid-HOLD SHALL abort the operation with no result emitted.

Verification (NIBBLES=4)
REQ-031 a=0x1234, b=0x0234, bin=0, out_ready=1 -> out_valid at accept+5 edges; diff=0x1000, borrow_out=0, zero=0; out_valid for one cycle.
REQ-032 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, borrow_out=1, zero=0. Also a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, borrow_out=1.
REQ-033 a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, borrow_out=0, zero=1; borrow ripples through all four nibbles.
REQ-034 Backpressure: out_ready=0 for 3 cycles in HOLD -> out_valid=1, diff/borrow_out/zero unchanged, in_ready=0. out_ready=1 -> IDLE next edge; in_ready=1 one cycle later.
REQ-035 in_valid held high with changing a/b during RUN -> result matches only the operands latched at accept; no second accept until IDLE.
REQ-036 rst_n pulsed low during RUN nibble 2 -> all outputs 0 immediately; no out_valid. The next accepted operation computes correctly.
